// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle multiply/divide sequencer owning HI/LO
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ph_q, ph_d, pl_q, pl_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [63:0] result;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, q_val, r_val;

  // Full 64-bit result of the op presented this cycle; signed divide works on
  // magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  always_comb begin
    a_neg   = (md_op == 3'd2) & A[31];
    b_neg   = (md_op == 3'd2) & B[31];
    a_mag   = a_neg ? (32'd0 - A) : A;
    b_mag   = b_neg ? (32'd0 - B) : B;
    div_den = (B == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / div_den;
    r_mag   = a_mag % div_den;
    q_val   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_val   = a_neg ? (32'd0 - r_mag) : r_mag;
    result  = {hi_q, lo_q};
    case (md_op)
      3'd0: result = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      3'd1: result = {32'd0, A} * {32'd0, B};
      3'd2, 3'd3: begin
        if (B != 32'd0) result = {r_val, q_val};
      end
      default: result = {hi_q, lo_q};
    endcase
  end

  // Next-state: accept ops in IDLE, count down in RUN, retire into HI/LO at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1: begin
              state_d      = S_RUN;
              cnt_d        = MULT_LAST;
              {ph_d, pl_d} = result;
            end
            3'd2, 3'd3: begin
              state_d      = S_RUN;
              cnt_d        = DIV_LAST;
              {ph_d, pl_d} = result;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = ph_q;
          lo_d    = pl_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // State register; reset abandons any in-flight op and clears HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign md_stall = md_use & (busy | (start & (md_op <= 3'd3)));

endmodule
